// File: rtl/dot_power_scheduler.sv
// Supply-budget scheduler for the H-bridge dot drivers: round-robin grants under a
// concurrency limit, fixed-length pulses and a per-dot cooldown lockout.
module dot_power_scheduler #(
  parameter int unsigned N_DOTS = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_DOTS-1:0] request,
  input  logic              abort,
  input  logic [4:0]        max_active,
  input  logic [CNT_W-1:0]  pulse_len,
  input  logic [CNT_W-1:0]  cooldown_len,
  output logic [N_DOTS-1:0] grant,
  output logic [N_DOTS-1:0] pulse_done,
  output logic [4:0]        active_count,
  output logic              throttled
);

  localparam int unsigned PTR_W = (N_DOTS > 1) ? $clog2(N_DOTS) : 1;
  localparam int unsigned ACT_W = 5;

  typedef enum logic [1:0] {IDLE, ON, COOL} dot_state_t;

  dot_state_t        state    [N_DOTS];
  dot_state_t        state_nx [N_DOTS];
  logic [CNT_W-1:0]  cnt      [N_DOTS];
  logic [CNT_W-1:0]  cnt_nx   [N_DOTS];
  logic [PTR_W-1:0]  rr_ptr, rr_nx;
  logic [N_DOTS-1:0] grant_nx, done_nx, eligible_c;
  logic [ACT_W-1:0]  limit_c, count_nx;
  logic [PTR_W-1:0]  winner_c, idx_c;
  logic [CNT_W-1:0]  pulse_eff_c;
  logic              found_c, under_limit_c, grant_go_c, throttle_c;

  // Eligibility, effective limit and round-robin winner search
  always_comb begin
    eligible_c = '0;
    for (int i = 0; i < N_DOTS; i++) begin
      eligible_c[i] = (state[i] == IDLE) && request[i];
    end
    limit_c     = (max_active > ACT_W'(N_DOTS)) ? ACT_W'(N_DOTS) : max_active;
    pulse_eff_c = (pulse_len == '0) ? CNT_W'(1) : pulse_len;
    found_c     = 1'b0;
    winner_c    = '0;
    idx_c       = '0;
    for (int k = 0; k < N_DOTS; k++) begin
      idx_c = PTR_W'((32'(rr_ptr) + 32'(k)) % N_DOTS);
      if (!found_c && eligible_c[idx_c]) begin
        found_c  = 1'b1;
        winner_c = idx_c;
      end
    end
    under_limit_c = active_count < limit_c;
    grant_go_c    = under_limit_c && found_c && !abort;
    throttle_c    = (|eligible_c) && !under_limit_c;
  end

  // Per-dot IDLE/ON/COOL next state; config is captured only on state entry
  always_comb begin
    grant_nx = grant;
    done_nx  = '0;
    count_nx = '0;
    for (int i = 0; i < N_DOTS; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      if (abort) begin
        state_nx[i] = IDLE;
        cnt_nx[i]   = '0;
        grant_nx[i] = 1'b0;
      end else begin
        case (state[i])
          IDLE: begin
            if (grant_go_c && (winner_c == PTR_W'(i))) begin
              state_nx[i] = ON;
              cnt_nx[i]   = pulse_eff_c;
              grant_nx[i] = 1'b1;
            end
          end
          ON: begin
            if (cnt[i] <= CNT_W'(1)) begin
              grant_nx[i] = 1'b0;
              done_nx[i]  = 1'b1;
              if (cooldown_len == '0) begin
                state_nx[i] = IDLE;
                cnt_nx[i]   = '0;
              end else begin
                state_nx[i] = COOL;
                cnt_nx[i]   = cooldown_len;
              end
            end else begin
              cnt_nx[i] = cnt[i] - CNT_W'(1);
            end
          end
          COOL: begin
            if (cnt[i] <= CNT_W'(1)) begin
              state_nx[i] = IDLE;
              cnt_nx[i]   = '0;
            end else begin
              cnt_nx[i] = cnt[i] - CNT_W'(1);
            end
          end
          default: begin
            state_nx[i] = IDLE;
            cnt_nx[i]   = '0;
            grant_nx[i] = 1'b0;
          end
        endcase
      end
      count_nx = count_nx + ACT_W'(grant_nx[i]);
    end
    rr_nx = grant_go_c ? PTR_W'((32'(winner_c) + 32'd1) % N_DOTS) : rr_ptr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_DOTS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      grant        <= '0;
      pulse_done   <= '0;
      active_count <= '0;
      throttled    <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      for (int i = 0; i < N_DOTS; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
      grant        <= grant_nx;
      pulse_done   <= done_nx;
      active_count <= count_nx;
      throttled    <= throttle_c;
      rr_ptr       <= rr_nx;
    end
  end

endmodule

// File: tb/tb_dot_power_scheduler.sv
// Self-checking bench for dot_power_scheduler: scenario tasks with scoreboard queues
// of expected grant rises / per-cycle output vectors.
module tb_dot_power_scheduler;

  logic        clock = 1'b0;
  logic        reset, abort;
  logic [15:0] request;
  logic [4:0]  max_active;
  logic [7:0]  pulse_len, cooldown_len;
  logic [15:0] grant, pulse_done;
  logic [4:0]  active_count;
  logic        throttled;

  dot_power_scheduler #(.N_DOTS(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .request(request), .abort(abort),
    .max_active(max_active), .pulse_len(pulse_len), .cooldown_len(cooldown_len),
    .grant(grant), .pulse_done(pulse_done), .active_count(active_count),
    .throttled(throttled)
  );

  always #5 clock = ~clock;

  typedef struct { int dot; int at; } ev_t;
  typedef struct { logic [15:0] g; logic [15:0] d; } vec_t;

  ev_t         sb[$];
  vec_t        vq[$];
  int          pass_cnt = 0;
  int          tot_cnt  = 0;
  int          e_idx    = 0;
  logic [15:0] prev_g;

  task automatic tick();
    @(posedge clock);
    #1;
    e_idx++;
  endtask

  task automatic do_reset(input logic [15:0] req, input logic [4:0] ma,
                          input logic [7:0] pl, input logic [7:0] cl);
    request = req; max_active = ma; pulse_len = pl; cooldown_len = cl;
    abort = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    e_idx = 0;
    prev_g = 16'h0;
    sb.delete();
    vq.delete();
  endtask

  task automatic test_reset();
    logic [15:0] rise, oh;
    ev_t ev;
    request = 16'hFFFF; max_active = 5'd16; pulse_len = 8'd10; cooldown_len = 8'd0;
    abort = 1'b0; reset = 1'b1;
    repeat (3) tick();
    tot_cnt++; if (grant !== 16'h0) $display("FAIL reset_grant got=%h exp=0", grant); else pass_cnt++;
    tot_cnt++; if (pulse_done !== 16'h0) $display("FAIL reset_done got=%h exp=0", pulse_done); else pass_cnt++;
    tot_cnt++; if (active_count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", active_count); else pass_cnt++;
    tot_cnt++; if (throttled !== 1'b0) $display("FAIL reset_throttled got=%b exp=0", throttled); else pass_cnt++;
    sb.delete();
    for (int k = 0; k < 4; k++) sb.push_back('{k, k + 1});
    reset = 1'b0; e_idx = 0; prev_g = 16'h0;
    repeat (4) begin
      tick();
      rise = grant & ~prev_g; prev_g = grant;
      if (rise != 16'h0) begin
        tot_cnt++;
        if (sb.size() == 0) $display("FAIL reset_order unexpected rise=%h at edge %0d", rise, e_idx);
        else begin
          ev = sb.pop_front(); oh = 16'h1 << ev.dot;
          if (rise !== oh || e_idx != ev.at)
            $display("FAIL reset_order got=%h@%0d exp=%h@%0d", rise, e_idx, oh, ev.at);
          else pass_cnt++;
        end
      end
    end
    tot_cnt++; if (sb.size() != 0) $display("FAIL reset_order missing=%0d exp=0", sb.size()); else pass_cnt++;
    tot_cnt++; if (active_count !== 5'd4) $display("FAIL reset_count4 got=%0d exp=4", active_count); else pass_cnt++;
  endtask

  task automatic test_limit();
    logic [15:0] rise, oh;
    ev_t ev;
    int max_seen = 0;
    do_reset(16'hFFFF, 5'd4, 8'd10, 8'd0);
    // groups of four grants, each group 11 cycles after the previous one
    for (int n = 0; n < 20; n++) sb.push_back('{n % 16, 1 + 11 * (n / 4) + (n % 4)});
    repeat (48) begin
      tick();
      if ($countones(grant) > max_seen) max_seen = $countones(grant);
      rise = grant & ~prev_g; prev_g = grant;
      if (rise != 16'h0) begin
        tot_cnt++;
        if (sb.size() == 0) $display("FAIL limit_order unexpected rise=%h at edge %0d", rise, e_idx);
        else begin
          ev = sb.pop_front(); oh = 16'h1 << ev.dot;
          if (rise !== oh || e_idx != ev.at)
            $display("FAIL limit_order got=%h@%0d exp=%h@%0d", rise, e_idx, oh, ev.at);
          else pass_cnt++;
        end
      end
      if (e_idx == 8) begin
        tot_cnt++; if (throttled !== 1'b1) $display("FAIL limit_throttled_on got=%b exp=1", throttled); else pass_cnt++;
      end
      if (e_idx == 12) begin
        tot_cnt++; if (throttled !== 1'b0) $display("FAIL limit_throttled_off got=%b exp=0", throttled); else pass_cnt++;
      end
    end
    tot_cnt++; if (max_seen != 4) $display("FAIL limit_max_active got=%0d exp=4", max_seen); else pass_cnt++;
    tot_cnt++; if (sb.size() != 0) $display("FAIL limit_order missing=%0d exp=0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_cooldown();
    vec_t v;
    logic g, d;
    do_reset(16'h0020, 5'd16, 8'd3, 8'd5);
    for (int e = 1; e <= 14; e++) begin
      g = ((e >= 1 && e <= 3) || (e >= 10 && e <= 12));
      d = (e == 4 || e == 13);
      vq.push_back('{g ? 16'h0020 : 16'h0, d ? 16'h0020 : 16'h0});
    end
    repeat (14) begin
      tick();
      v = vq.pop_front();
      tot_cnt++; if (grant !== v.g) $display("FAIL cool_grant edge=%0d got=%h exp=%h", e_idx, grant, v.g); else pass_cnt++;
      tot_cnt++; if (pulse_done !== v.d) $display("FAIL cool_done edge=%0d got=%h exp=%h", e_idx, pulse_done, v.d); else pass_cnt++;
    end
  endtask

  task automatic test_zero_cases();
    vec_t v;
    do_reset(16'h0004, 5'd16, 8'd0, 8'd0);
    vq.push_back('{16'h0004, 16'h0000});
    vq.push_back('{16'h0000, 16'h0004});
    vq.push_back('{16'h0004, 16'h0000});
    vq.push_back('{16'h0000, 16'h0004});
    repeat (4) begin
      tick();
      v = vq.pop_front();
      tot_cnt++; if (grant !== v.g) $display("FAIL zero_pulse_grant edge=%0d got=%h exp=%h", e_idx, grant, v.g); else pass_cnt++;
      tot_cnt++; if (pulse_done !== v.d) $display("FAIL zero_pulse_done edge=%0d got=%h exp=%h", e_idx, pulse_done, v.d); else pass_cnt++;
    end
    do_reset(16'h00F0, 5'd0, 8'd4, 8'd0);
    repeat (3) begin
      tick();
      tot_cnt++; if (grant !== 16'h0) $display("FAIL zero_limit_grant got=%h exp=0", grant); else pass_cnt++;
      tot_cnt++; if (throttled !== 1'b1) $display("FAIL zero_limit_throttled got=%b exp=1", throttled); else pass_cnt++;
    end
    do_reset(16'hFFFF, 5'd31, 8'd20, 8'd0);
    repeat (16) tick();
    tot_cnt++; if (grant !== 16'hFFFF) $display("FAIL limit31_grant got=%h exp=ffff", grant); else pass_cnt++;
    tot_cnt++; if (active_count !== 5'd16) $display("FAIL limit31_count got=%0d exp=16", active_count); else pass_cnt++;
    tick();
    tot_cnt++; if (throttled !== 1'b0) $display("FAIL limit31_throttled got=%b exp=0", throttled); else pass_cnt++;
  endtask

  task automatic test_abort();
    do_reset(16'h0007, 5'd16, 8'd10, 8'd0);
    repeat (3) tick();
    tot_cnt++; if (grant !== 16'h0007) $display("FAIL abort_pre got=%h exp=0007", grant); else pass_cnt++;
    abort = 1'b1; request = 16'hFFFF;
    tick();
    abort = 1'b0;
    tot_cnt++; if (grant !== 16'h0) $display("FAIL abort_grant got=%h exp=0", grant); else pass_cnt++;
    tot_cnt++; if (active_count !== 5'd0) $display("FAIL abort_count got=%0d exp=0", active_count); else pass_cnt++;
    tot_cnt++; if (pulse_done !== 16'h0) $display("FAIL abort_done got=%h exp=0", pulse_done); else pass_cnt++;
    tick();
    tot_cnt++; if (grant !== 16'h0008) $display("FAIL abort_next got=%h exp=0008", grant); else pass_cnt++;
    tot_cnt++; if (pulse_done !== 16'h0) $display("FAIL abort_done2 got=%h exp=0", pulse_done); else pass_cnt++;
  endtask

  task automatic test_reconfig();
    logic [15:0] rise, oh;
    ev_t ev;
    do_reset(16'hFFFF, 5'd4, 8'd8, 8'd0);
    sb.push_back('{0, 1});  sb.push_back('{1, 2});  sb.push_back('{2, 3});
    sb.push_back('{3, 4});  sb.push_back('{4, 13}); sb.push_back('{5, 22});
    sb.push_back('{6, 25});
    repeat (25) begin
      tick();
      rise = grant & ~prev_g; prev_g = grant;
      if (rise != 16'h0) begin
        tot_cnt++;
        if (sb.size() == 0) $display("FAIL reconf_order unexpected rise=%h at edge %0d", rise, e_idx);
        else begin
          ev = sb.pop_front(); oh = 16'h1 << ev.dot;
          if (rise !== oh || e_idx != ev.at)
            $display("FAIL reconf_order got=%h@%0d exp=%h@%0d", rise, e_idx, oh, ev.at);
          else pass_cnt++;
        end
      end
      if (e_idx == 4) max_active = 5'd1;
      if (e_idx == 12) begin
        tot_cnt++; if (active_count !== 5'd0) $display("FAIL reconf_count0 got=%0d exp=0", active_count); else pass_cnt++;
      end
      if (e_idx == 13) begin
        pulse_len = 8'd2;
        tot_cnt++; if (active_count !== 5'd1) $display("FAIL reconf_count1 got=%0d exp=1", active_count); else pass_cnt++;
      end
      if (e_idx == 20) begin
        tot_cnt++; if (grant !== 16'h0010) $display("FAIL reconf_len_hold got=%h exp=0010", grant); else pass_cnt++;
      end
      if (e_idx == 21 || e_idx == 24) begin
        tot_cnt++; if (grant !== 16'h0) $display("FAIL reconf_fall edge=%0d got=%h exp=0", e_idx, grant); else pass_cnt++;
      end
    end
    tot_cnt++; if (sb.size() != 0) $display("FAIL reconf_order missing=%0d exp=0", sb.size()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_limit();
    test_cooldown();
    test_zero_cases();
    test_abort();
    test_reconfig();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
